// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks a PC through instruction memory,
// handling stall, halt and branch redirects, and counts issued instructions.
//
// state | meaning
// IDLE  | waiting for start; nothing issued
// RUN   | fetching; one instruction per non-stalled cycle
// DONE  | program ended (halt, run-off-end or bad branch); results frozen
module fetch_unit #(
  parameter int NUM_INSTR = 128  // legal range 2..128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        branch_taken,
  input  logic [6:0]  branch_target,
  input  logic [8:0]  instruction,
  output logic [6:0]  address,
  output logic [8:0]  instr_out,
  output logic        instr_valid,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // 8-bit limit so NUM_INSTR=128 compares correctly against a 7-bit target
  localparam logic [7:0] NUM_LIMIT = 8'(NUM_INSTR);
  localparam logic [6:0] LAST_PC   = 7'(NUM_INSTR - 1);

  state_t      state, state_nxt;
  logic [6:0]  pc, pc_nxt;
  logic [15:0] count, count_nxt;
  logic        fault_q, fault_nxt;
  logic        target_ok;
  logic        issue;

  assign target_ok = ({1'b0, branch_target} < NUM_LIMIT);
  assign issue     = (state == RUN) && !stall;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    count_nxt = count;
    fault_nxt = fault_q;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          pc_nxt    = 7'd0;
          count_nxt = 16'd0;
          fault_nxt = 1'b0;
        end
      end

      RUN: begin
        if (issue && (count != 16'hFFFF)) begin
          count_nxt = count + 16'd1;
        end

        if (halt_req) begin
          state_nxt = DONE;
        end else if (stall) begin
          // branch presented during a stall is dropped; decoder re-presents it
          pc_nxt = pc;
        end else if (branch_taken && target_ok) begin
          pc_nxt = branch_target;
        end else if (branch_taken) begin
          state_nxt = DONE;
          fault_nxt = 1'b1;
        end else if (pc == LAST_PC) begin
          state_nxt = DONE;
        end else begin
          pc_nxt = pc + 7'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
        pc_nxt    = 7'd0;
        count_nxt = 16'd0;
        fault_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      pc      <= 7'd0;
      count   <= 16'd0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      count   <= count_nxt;
      fault_q <= fault_nxt;
    end
  end

  // memory is combinational, so the PC register drives the fetch directly
  assign address     = pc;
  assign instr_out   = instruction;
  assign instr_valid = issue;
  assign busy        = (state == RUN);
  assign done        = (state == DONE);
  assign fault       = fault_q;
  assign instr_count = count;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Parameters
REQ-001 NUM_INSTR, 128, number of valid instruction-memory words; legal addresses are 0..NUM_INSTR-1; NUM_INSTR SHALL be in the range 2..128.

Interface
REQ-002 clk  input  1  single clock; every register updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  program start request; sampled only in IDLE or DONE.
REQ-005 stall  input  1  holds the PC and suppresses instr_valid while high.
REQ-006 halt_req  input  1  decoder request to end the program after the current instruction.
REQ-007 branch_taken  input  1  a redirect is taken this cycle.
REQ-008 branch_target  input  7  absolute redirect address.
REQ-009 instruction  input  9  word returned by the instruction memory for the current address, combinationally.
REQ-010 address  output  7  instruction-memory address; equals the PC register.
REQ-011 instr_out  output  9  instruction passed to the decoder; equals instruction, combinationally.
REQ-012 instr_valid  output  1  instr_out is a live instruction this cycle.
REQ-013 busy  output  1  high in RUN.
REQ-014 done  output  1  high in DONE.
REQ-015 fault  output  1  sticky flag: the program ended on an out-of-range branch target.
REQ-016 instr_count  output  16  count of instructions issued in the current run; saturates at 16'hFFFF.

Function
REQ-017 The FSM SHALL have three states: IDLE (encoding 0), RUN and DONE.
REQ-018 In IDLE, start=1 SHALL, on the next edge, go to RUN with PC=0, instr_count=0 and fault=0.
REQ-019 In DONE, start=1 SHALL behave as in IDLE; otherwise DONE SHALL hold, with PC, instr_count and fault frozen.
REQ-020 start SHALL be ignored in RUN.
REQ-021 instr_valid SHALL equal (state==RUN) AND NOT stall; busy SHALL equal (state==RUN); done SHALL equal (state==DONE).
REQ-022 Each RUN-state edge SHALL apply the first matching rule, highest priority first:
- halt_req: go to DONE; the PC holds.
- stall: the PC holds; state holds.
- branch_taken with branch_target < NUM_INSTR: PC = branch_target.
- branch_taken with branch_target >= NUM_INSTR: go to DONE; fault=1; the PC holds.
- PC == NUM_INSTR-1: go to DONE, because the program runs off the end.
- otherwise: PC = PC+1.
REQ-023 halt_req SHALL be honoured during stall; stall SHALL override branch_taken, so the branch is lost and the decoder must re-present it.
REQ-024 instr_count SHALL increment on every RUN edge where instr_valid=1, including the edge that leaves for DONE, and SHALL not wrap.
REQ-025 Fetch latency SHALL be zero cycles: a PC updated on edge N SHALL drive address, and therefore instr_out, during cycle N+1.
REQ-026 The PC SHALL never take a value >= NUM_INSTR.

Reset
REQ-027 With rst_n=0 at an edge, the block SHALL set state=IDLE, PC=0, instr_count=0 and fault=0, from any state including mid-RUN.
REQ-028 Reset SHALL take priority over start, halt_req, stall and branch_taken.
REQ-029 Values after reset: address=0, instr_valid=0, busy=0, done=0, fault=0, instr_count=0.

Verification
REQ-030 Sequential run, NUM_INSTR=8: start pulse, no other inputs -> address 0..7 on consecutive cycles, then done=1, instr_count=8, fault=0.
REQ-031 Branch: at PC=3, branch_taken=1 with branch_target=6 -> next address=6; a target of 7'd100 -> DONE with fault=1 and instr_count=4.
REQ-032 Stall and priority: stall for 3 cycles at PC=2 -> address stays 2, instr_valid=0, instr_count unchanged; stall together with branch_taken -> PC holds; halt_req together with stall -> DONE.
REQ-033 Restart: start in DONE -> RUN with address=0, instr_count=0, fault cleared; start while in RUN -> no effect.
REQ-034 Reset mid-run: rst_n=0 at PC=5 -> next cycle IDLE with address=0 and all outputs at reset values; rst_n=0 together with start -> remains IDLE.
REQ-035 Saturation: hold the PC in a self-branch (branch_target equal to the current PC) for 70000 cycles -> instr_count=16'hFFFF and no wrap.
